// File: rtl/mux_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_select_arbiter
// Brief    : Round-robin owner arbiter driving the select of a shared 4:1 mux.
//            Optional macro MUX_ARB_PREEMPT_EN enables MAX_HOLD preemption.
// Revision : 1.0 - initial release
// ============================================================================
module mux_select_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       grant,
  output logic [1:0]       S,
  output logic             sel_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
`ifdef MUX_ARB_PREEMPT_EN
  localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
`else
  localparam logic [CNT_W-1:0] c_cnt_sat = {CNT_W{1'b1}};
`endif

  if (MAX_HOLD < 1 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("mux_select_arbiter: need MAX_HOLD >= 1 and 2**CNT_W > MAX_HOLD");
  end

  state_t           r_state;
  logic [3:0]       r_grant;
  logic [1:0]       r_s;
  logic [1:0]       r_last_owner;
  logic             r_sel_valid;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [1:0] w_base;
  logic [3:0] w_cand;
  logic       w_any;
  logic [1:0] w_winner;
  logic [3:0] w_winner_oh;

  // The current owner never competes against itself, so a preempted owner
  // only keeps the bus when no one else is asking.
  always_comb begin
    w_base   = (r_state == ST_GRANT) ? r_s : r_last_owner;
    w_cand   = req;
    if (r_state == ST_GRANT) begin
      w_cand[r_s] = 1'b0;
    end
    w_any    = |w_cand;
    w_winner = w_base;
    for (int i = 4; i >= 1; i--) begin
      if (w_cand[2'(w_base + 2'(i))]) begin
        w_winner = 2'(w_base + 2'(i));
      end
    end
    w_winner_oh = 4'b0001 << w_winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 4'b0000;
      r_s          <= 2'b00;
      r_sel_valid  <= 1'b0;
      r_hold_cnt   <= '0;
      r_last_owner <= 2'd3;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_GRANT;
            r_grant     <= w_winner_oh;
            r_s         <= w_winner;
            r_sel_valid <= 1'b1;
            r_hold_cnt  <= c_cnt_one;
          end
        end
        ST_GRANT: begin
          if (!req[r_s]) begin
            r_last_owner <= r_s;
            if (w_any) begin
              r_grant    <= w_winner_oh;
              r_s        <= w_winner;
              r_hold_cnt <= c_cnt_one;
            end else begin
              r_state     <= ST_IDLE;
              r_grant     <= 4'b0000;
              r_sel_valid <= 1'b0;
              r_hold_cnt  <= '0;
            end
          end
`ifdef MUX_ARB_PREEMPT_EN
          else if (r_hold_cnt == c_max_hold) begin
            if (w_any) begin
              r_last_owner <= r_s;
              r_grant      <= w_winner_oh;
              r_s          <= w_winner;
              r_hold_cnt   <= c_cnt_one;
            end else begin
              r_hold_cnt <= c_cnt_one;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + c_cnt_one;
          end
`else
          else if (r_hold_cnt != c_cnt_sat) begin
            r_hold_cnt <= r_hold_cnt + c_cnt_one;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign S         = r_s;
  assign sel_valid = r_sel_valid;
  assign hold_cnt  = r_hold_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_select_arbiter
// Brief    : Directed self-checking bench for mux_select_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_select_arbiter;

  localparam int CNT_W    = 4;
  localparam int MAX_HOLD = 8;
`ifdef MUX_ARB_PREEMPT_EN
  localparam int HOLD_LIM = MAX_HOLD;
`else
  localparam int HOLD_LIM = (2 ** CNT_W) - 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = 4'b0000;
  logic [3:0]       grant;
  logic [1:0]       S;
  logic             sel_valid;
  logic [CNT_W-1:0] hold_cnt;

  logic [3:0] mux_i = 4'b1010;
  logic       y;
  assign y = mux_i[S];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  mux_select_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .S        (S),
    .sel_valid(sel_valid),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  // Invariant monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [1:0] idx;
      logic       bad;
      idx = grant[3] ? 2'd3 : grant[2] ? 2'd2 : grant[1] ? 2'd1 : 2'd0;
      bad = ((grant & (grant - 4'd1)) != 4'd0) || (sel_valid !== (|grant)) ||
            (sel_valid && (S !== idx)) ||
            (sel_valid ? (hold_cnt == 0 || int'(hold_cnt) > HOLD_LIM) : (hold_cnt != 0));
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL invariant @%0t: grant=%b S=%0d sel_valid=%b hold_cnt=%0d", $time,
                 grant, S, sel_valid, hold_cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    step();
    mon_en = 1'b1;
    vectors++;
    if (grant !== 4'b0000 || S !== 2'b00 || sel_valid !== 1'b0 || hold_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: got grant=%b S=%0d v=%b h=%0d want 0000/0/0/0",
               grant, S, sel_valid, hold_cnt);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (grant !== 4'b0001 || S !== 2'b00 || sel_valid !== 1'b1 || hold_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL first_grant: got grant=%b S=%0d v=%b h=%0d want 0001/0/1/1",
               grant, S, sel_valid, hold_cnt);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_y;
    exp_y = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (grant !== (4'b0001 << k) || S !== 2'(k) || hold_cnt !== 4'd1) begin
        miscompares++;
        $display("FAIL rotation_grant[%0d]: got grant=%b S=%0d h=%0d want %b/%0d/1",
                 k, grant, S, hold_cnt, 4'b0001 << k, k);
      end
      vectors++;
      if (y !== exp_y[k]) begin
        miscompares++;
        $display("FAIL rotation_mux_y[%0d]: got %b want %b", k, y, exp_y[k]);
      end
      req = 4'b1111;
      step();
      vectors++;
      if (grant !== (4'b0001 << k) || hold_cnt !== 4'd2) begin
        miscompares++;
        $display("FAIL rotation_hold[%0d]: got grant=%b h=%0d want %b/2",
                 k, grant, hold_cnt, 4'b0001 << k);
      end
      req = 4'b1111 & ~(4'b0001 << k);
      step();
    end
    vectors++;
    if (grant !== 4'b0001 || S !== 2'd0) begin
      miscompares++;
      $display("FAIL rotation_wrap: got grant=%b S=%0d want 0001/0", grant, S);
    end
  endtask

  task automatic test_preempt();
    logic [3:0] eg;
    int         eh;
    do_reset(4'b0101);
    step();
    for (int c = 0; c < 24; c++) begin
      if (c > 0) step();
`ifdef MUX_ARB_PREEMPT_EN
      eg = ((c / 8) % 2 == 1) ? 4'b0100 : 4'b0001;
      eh = (c % 8) + 1;
`else
      eg = 4'b0001;
      eh = (c + 1 > 15) ? 15 : c + 1;
`endif
      vectors++;
      if (grant !== eg || int'(hold_cnt) != eh) begin
        miscompares++;
        $display("FAIL preempt[c=%0d]: got grant=%b h=%0d want %b/%0d", c, grant, hold_cnt,
                 eg, eh);
      end
    end
  endtask

  task automatic test_sole_requester();
    int eh;
    do_reset(4'b0010);
    step();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) step();
`ifdef MUX_ARB_PREEMPT_EN
      eh = (c % 8) + 1;
`else
      eh = (c + 1 > 15) ? 15 : c + 1;
`endif
      vectors++;
      if (grant !== 4'b0010 || S !== 2'd1 || int'(hold_cnt) != eh) begin
        miscompares++;
        $display("FAIL sole[c=%0d]: got grant=%b S=%0d h=%0d want 0010/1/%0d", c, grant, S,
                 hold_cnt, eh);
      end
    end
  endtask

  task automatic test_release_idle();
    do_reset(4'b0100);
    step();
    step();
    vectors++;
    if (grant !== 4'b0100 || S !== 2'd2) begin
      miscompares++;
      $display("FAIL idle_setup: got grant=%b S=%0d want 0100/2", grant, S);
    end
    req = 4'b0000;
    step();
    vectors++;
    if (grant !== 4'b0000 || sel_valid !== 1'b0 || S !== 2'd2 || hold_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL release_idle: got grant=%b v=%b S=%0d h=%0d want 0000/0/2/0", grant,
               sel_valid, S, hold_cnt);
    end
    step();
    vectors++;
    if (grant !== 4'b0000 || S !== 2'd2) begin
      miscompares++;
      $display("FAIL idle_stay: got grant=%b S=%0d want 0000/2", grant, S);
    end
    req = 4'b1001;
    step();
    vectors++;
    if (grant !== 4'b1000 || S !== 2'd3 || hold_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL idle_regrant: got grant=%b S=%0d h=%0d want 1000/3/1", grant, S,
               hold_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset(4'b0100);
    step();
    vectors++;
    if (grant !== 4'b0100) begin
      miscompares++;
      $display("FAIL async_setup: got grant=%b want 0100", grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (grant !== 4'b0000 || sel_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_drop: got grant=%b v=%b want 0000/0", grant, sel_valid);
    end
    req   = 4'b1111;
    rst_n = 1'b1;
    step();
    vectors++;
    if (grant !== 4'b0001 || S !== 2'd0) begin
      miscompares++;
      $display("FAIL async_restart: got grant=%b S=%0d want 0001/0", grant, S);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_preempt();
    test_sole_requester();
    test_release_idle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
